// File: rtl/ddr_train_pkg.sv
// Shared types for the DDR training sequencer: stage encoding, FSM states
// and the fixed-priority stage picker.
// Latency: n/a (types and a pure function). Backpressure: n/a.
// Contents: NB_STAGE, train_stage_e, train_state_e, first_pend().
package ddr_train_pkg;

  localparam int NB_STAGE = 6;

  // Lower encoding = higher priority when several stages are pending.
  typedef enum logic [2:0] {
    STAGE_ZQ      = 3'd0,
    STAGE_CA      = 3'd1,
    STAGE_WR_LVL  = 3'd2,
    STAGE_RD_GATE = 3'd3,
    STAGE_RD_LVL  = 3'd4,
    STAGE_WR_DQ   = 3'd5
  } train_stage_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_NEXT = 2'd2,
    ST_FIN  = 2'd3
  } train_state_e;

  // Lowest-numbered pending stage; ZQ when nothing is pending.
  function automatic train_stage_e first_pend(input logic [NB_STAGE-1:0] pend);
    train_stage_e sel;
    sel = STAGE_ZQ;
    for (int i = NB_STAGE - 1; i >= 0; i--) begin
      if (pend[i]) sel = train_stage_e'(i[2:0]);
    end
    return sel;
  endfunction

endpackage

// File: rtl/ddr_train_timer.sv
// Loadable up-counter used as the per-request PHY ack timeout.
// Latency: count updates one edge after clr/ld/en; expired_o is combinational.
// Backpressure: none; counts whenever en_i is high.
// Ports: clk_i/rst_i (sync active-high), clr_i (highest priority), ld_i/ld_val_i,
//        en_i, limit_i (terminal count), expired_o (en_i && count == limit_i).
module ddr_train_timer #(
  parameter int TO_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            ld_i,
  input  logic [TO_W-1:0] ld_val_i,
  input  logic            en_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (ld_i) cnt_d = ld_val_i;
    else if (en_i) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/ddr_training_sequencer.sv
// Latches training start edges, serialises stages by fixed priority and runs
// each stage over all ranks via req/ack to the PHY. Latency: start edge -> req in 2 edges.
// Backpressure: req held until ack or timeout; starts arriving while busy queue in pend.
// Ports: pclk_i/prst_i (sync active-high); *_training_start_i in, sticky *_training_done_o,
//        train_fail_o[6], train_busy_o; phy_train_req/type/rank_o, phy_train_ack/pass_i.
// Optional macro TRAIN_RETRY_EN: a failed or timed-out rank request is reissued once.
module ddr_training_sequencer
  import ddr_train_pkg::*;
#(
  parameter int NB_RANK        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16,
  localparam int RW            = $clog2(NB_RANK)
) (
  input  logic          pclk_i,
  input  logic          prst_i,
  input  logic          ca_training_start_i,
  input  logic          wr_dq_training_start_i,
  input  logic          wr_lvl_training_start_i,
  input  logic          rd_lvl_training_start_i,
  input  logic          rd_gate_training_start_i,
  input  logic          zq_training_start_i,
  input  logic          all_training_start_i,
  output logic          ca_training_done_o,
  output logic          wr_dq_training_done_o,
  output logic          wr_lvl_training_done_o,
  output logic          rd_lvl_training_done_o,
  output logic          rd_gate_training_done_o,
  output logic          zq_training_done_o,
  output logic          all_training_done_o,
  output logic [5:0]    train_fail_o,
  output logic          train_busy_o,
  output logic          phy_train_req_o,
  output logic [2:0]    phy_train_type_o,
  output logic [RW-1:0] phy_train_rank_o,
  input  logic          phy_train_ack_i,
  input  logic          phy_train_pass_i
);

  localparam logic [RW-1:0] LAST_RANK = RW'(NB_RANK - 1);

  train_state_e          state_q, state_d;
  train_stage_e          stage_q, stage_d;
  logic [RW-1:0]         rank_q, rank_d;
  logic [NB_STAGE:0]     start_q, start_d;
  logic [NB_STAGE-1:0]   pend_q, pend_d;
  logic                  pend_all_q, pend_all_d;
  logic [NB_STAGE-1:0]   done_q, done_d;
  logic                  all_done_q, all_done_d;
  logic [NB_STAGE-1:0]   fail_q, fail_d;
  logic                  rank_fail_q, rank_fail_d;
  logic                  retry_now;
  logic                  tmr_expired;
  logic [NB_STAGE:0]     start_vec;
  logic [NB_STAGE:0]     start_rise;

  // Bit index equals stage encoding; bit NB_STAGE is the all-stages start.
  assign start_vec  = {all_training_start_i, wr_dq_training_start_i, rd_lvl_training_start_i,
                       rd_gate_training_start_i, wr_lvl_training_start_i,
                       ca_training_start_i, zq_training_start_i};
  assign start_rise = start_vec & ~start_q;

`ifdef TRAIN_RETRY_EN
  logic retry_q, retry_d;
  // A failed first attempt on this rank goes back to REQ instead of advancing.
  assign retry_now = rank_fail_q && !retry_q;
`else
  assign retry_now = 1'b0;
`endif

  ddr_train_timer #(.TO_W(TO_W)) u_timer (
    .clk_i     (pclk_i),
    .rst_i     (prst_i),
    .clr_i     (state_q != ST_REQ),
    .ld_i      (1'b0),
    .ld_val_i  ('0),
    .en_i      (state_q == ST_REQ),
    .limit_i   (TO_W'(TIMEOUT_CYCLES - 1)),
    .expired_o (tmr_expired)
  );

  // FSM: state register
  always_ff @(posedge pclk_i) begin
    if (prst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|pend_q) state_d = ST_REQ;
      ST_REQ:  if (phy_train_ack_i || tmr_expired) state_d = ST_NEXT;
      ST_NEXT: begin
        if (retry_now || rank_q != LAST_RANK) state_d = ST_REQ;
        else                                  state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    phy_train_req_o  = (state_q == ST_REQ);
    train_busy_o     = (state_q != ST_IDLE);
    phy_train_type_o = stage_q;
    phy_train_rank_o = rank_q;
  end

  // Datapath next values
  always_comb begin
    stage_d     = stage_q;
    rank_d      = rank_q;
    start_d     = start_vec;
    pend_d      = pend_q;
    pend_all_d  = pend_all_q;
    done_d      = done_q;
    all_done_d  = all_done_q;
    fail_d      = fail_q;
    rank_fail_d = rank_fail_q;
`ifdef TRAIN_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          stage_d         = first_pend(pend_q);
          pend_d[stage_d] = 1'b0;
          rank_d          = '0;
        end
      end
      ST_REQ: begin
        // Ack has priority over a coincident timeout so a late pass still counts.
        if (phy_train_ack_i)  rank_fail_d = !phy_train_pass_i;
        else if (tmr_expired) rank_fail_d = 1'b1;
      end
      ST_NEXT: begin
        if (retry_now) begin
`ifdef TRAIN_RETRY_EN
          retry_d = 1'b1;
`endif
        end else begin
`ifdef TRAIN_RETRY_EN
          retry_d = 1'b0;
`endif
          if (rank_fail_q) fail_d[stage_q] = 1'b1;
          if (rank_q != LAST_RANK) begin
            rank_d = rank_q + RW'(1);
          end else begin
            // Flags commit on the edge into FIN so done is visible one edge
            // after the last-rank ack.
            done_d[stage_q] = 1'b1;
            if (pend_all_q && pend_q == '0) begin
              all_done_d = 1'b1;
              pend_all_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase

    // Start edges take effect last so they override a same-edge completion.
    if (start_rise[NB_STAGE]) begin
      pend_d     = '1;
      pend_all_d = 1'b1;
      done_d     = '0;
      all_done_d = 1'b0;
      fail_d     = '0;
    end
    for (int i = 0; i < NB_STAGE; i++) begin
      if (start_rise[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        done_d[i] = 1'b0;
        fail_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      stage_q     <= STAGE_ZQ;
      rank_q      <= '0;
      start_q     <= '0;
      pend_q      <= '0;
      pend_all_q  <= 1'b0;
      done_q      <= '0;
      all_done_q  <= 1'b0;
      fail_q      <= '0;
      rank_fail_q <= 1'b0;
`ifdef TRAIN_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      stage_q     <= stage_d;
      rank_q      <= rank_d;
      start_q     <= start_d;
      pend_q      <= pend_d;
      pend_all_q  <= pend_all_d;
      done_q      <= done_d;
      all_done_q  <= all_done_d;
      fail_q      <= fail_d;
      rank_fail_q <= rank_fail_d;
`ifdef TRAIN_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign zq_training_done_o      = done_q[STAGE_ZQ];
  assign ca_training_done_o      = done_q[STAGE_CA];
  assign wr_lvl_training_done_o  = done_q[STAGE_WR_LVL];
  assign rd_gate_training_done_o = done_q[STAGE_RD_GATE];
  assign rd_lvl_training_done_o  = done_q[STAGE_RD_LVL];
  assign wr_dq_training_done_o   = done_q[STAGE_WR_DQ];
  assign all_training_done_o     = all_done_q;
  assign train_fail_o            = fail_q;

endmodule
